// File: rtl/soc_addr_map_unit.sv
// Runtime-programmable address map: N base/length rules decoded to a slave index with one register stage.
// Optional per-rule hit and miss counters are compiled in when ADDR_MAP_STATS_EN is defined.
module soc_addr_map_unit #(
  parameter int unsigned NrRules   = 10,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned IdxWidth  = (NrRules > 1) ? $clog2(NrRules) : 1,
  parameter logic [NrRules-1:0][AddrWidth-1:0] RstBase   = '0,
  parameter logic [NrRules-1:0][AddrWidth-1:0] RstLength = '0,
  parameter logic [NrRules-1:0][1:0]           RstAttr   = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [IdxWidth-1:0]  rsp_idx_o,
  output logic                 rsp_hit_o,
  output logic                 rsp_multi_o,
  output logic                 rsp_exec_o,
  output logic                 rsp_cached_o,
  input  logic                 cfg_req_i,
  input  logic                 cfg_we_i,
  input  logic [4:0]           cfg_idx_i,
  input  logic [1:0]           cfg_field_i,
  input  logic [AddrWidth-1:0] cfg_wdata_i,
  output logic [AddrWidth-1:0] cfg_rdata_o,
  output logic                 cfg_err_o,
  input  logic                 lock_i,
  output logic                 locked_o
);

  localparam logic [5:0] NrRulesW = 6'(NrRules);
`ifdef ADDR_MAP_STATS_EN
  localparam logic StatsEn = 1'b1;
`else
  localparam logic StatsEn = 1'b0;
`endif

  logic [AddrWidth-1:0] base_q [NrRules];
  logic [AddrWidth-1:0] len_q  [NrRules];
  logic [1:0]           attr_q [NrRules];
  logic                 locked_q;

  logic                 rsp_valid_q, rsp_hit_q, rsp_multi_q, rsp_exec_q, rsp_cached_q;
  logic [IdxWidth-1:0]  rsp_idx_q;
  logic [AddrWidth-1:0] cfg_rdata_q, rdata_d;
  logic                 cfg_err_q;

  logic [NrRules-1:0]   match;
  logic [IdxWidth-1:0]  win_idx_d;
  logic [1:0]           win_attr_d;
  logic                 hit_d, multi_d, accept;
  logic                 idx_in_range, rd_idx_ok, wr_ok, wr_err, rd_err;

  // Subtract only after the >= check so a rule never wraps past the top of the address space.
  for (genvar gi = 0; gi < NrRules; gi++) begin : g_match
    assign match[gi] = (len_q[gi] != '0) && (req_addr_i >= base_q[gi]) &&
                       ((req_addr_i - base_q[gi]) < len_q[gi]);
  end

  always_comb begin
    win_idx_d  = '0;
    win_attr_d = 2'b00;
    hit_d      = 1'b0;
    multi_d    = 1'b0;
    for (int unsigned i = 0; i < NrRules; i++) begin
      if (match[i]) begin
        if (hit_d) begin
          multi_d = 1'b1;
        end else begin
          win_idx_d  = IdxWidth'(i);
          win_attr_d = attr_q[i];
        end
        hit_d = 1'b1;
      end
    end
  end

  assign req_ready_o = !rsp_valid_q || rsp_ready_i;
  assign accept      = req_valid_i && req_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_q  <= 1'b0;
      rsp_idx_q    <= '0;
      rsp_hit_q    <= 1'b0;
      rsp_multi_q  <= 1'b0;
      rsp_exec_q   <= 1'b0;
      rsp_cached_q <= 1'b0;
    end else if (accept) begin
      rsp_valid_q  <= 1'b1;
      rsp_idx_q    <= win_idx_d;
      rsp_hit_q    <= hit_d;
      rsp_multi_q  <= multi_d;
      rsp_exec_q   <= win_attr_d[0];
      rsp_cached_q <= win_attr_d[1];
    end else if (rsp_ready_i) begin
      rsp_valid_q  <= 1'b0;
    end
  end

  assign idx_in_range = {1'b0, cfg_idx_i} < NrRulesW;
  // The miss counter lives one slot past the last rule and is only reachable through the stats field.
  assign rd_idx_ok = idx_in_range ||
                     (StatsEn && cfg_field_i == 2'd3 && {1'b0, cfg_idx_i} == NrRulesW);
  assign wr_ok  = cfg_req_i && cfg_we_i && !locked_q && idx_in_range && cfg_field_i != 2'd3;
  assign wr_err = cfg_req_i && cfg_we_i && !wr_ok;
  assign rd_err = cfg_req_i && !cfg_we_i && !rd_idx_ok;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NrRules; i++) begin
        base_q[i] <= RstBase[i];
        len_q[i]  <= RstLength[i];
        attr_q[i] <= RstAttr[i];
      end
      locked_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NrRules; i++) begin
        if (wr_ok && {1'b0, cfg_idx_i} == 6'(i)) begin
          case (cfg_field_i)
            2'd0:    base_q[i] <= cfg_wdata_i;
            2'd1:    len_q[i]  <= cfg_wdata_i;
            2'd2:    attr_q[i] <= cfg_wdata_i[1:0];
            default: ;
          endcase
        end
      end
      locked_q <= locked_q | lock_i;
    end
  end

`ifdef ADDR_MAP_STATS_EN
  logic [31:0] cnt_q [NrRules+1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i <= NrRules; i++) cnt_q[i] <= '0;
    end else if (accept) begin
      for (int unsigned i = 0; i < NrRules; i++) begin
        if (hit_d && win_idx_d == IdxWidth'(i) && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + 32'd1;
      end
      if (!hit_d && cnt_q[NrRules] != '1) cnt_q[NrRules] <= cnt_q[NrRules] + 32'd1;
    end
  end
`endif

  always_comb begin
    rdata_d = '0;
    for (int unsigned i = 0; i < NrRules; i++) begin
      if ({1'b0, cfg_idx_i} == 6'(i)) begin
        case (cfg_field_i)
          2'd0:    rdata_d = base_q[i];
          2'd1:    rdata_d = len_q[i];
          2'd2:    rdata_d = AddrWidth'(attr_q[i]);
          default: rdata_d = '0;
        endcase
      end
    end
`ifdef ADDR_MAP_STATS_EN
    if (cfg_field_i == 2'd3) begin
      for (int unsigned i = 0; i <= NrRules; i++) begin
        if ({1'b0, cfg_idx_i} == 6'(i)) rdata_d = AddrWidth'(cnt_q[i]);
      end
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_rdata_q <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_rdata_q <= (cfg_req_i && !cfg_we_i && rd_idx_ok) ? rdata_d : '0;
      cfg_err_q   <= wr_err || rd_err;
    end
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_idx_o    = rsp_idx_q;
  assign rsp_hit_o    = rsp_hit_q;
  assign rsp_multi_o  = rsp_multi_q;
  assign rsp_exec_o   = rsp_exec_q;
  assign rsp_cached_o = rsp_cached_q;
  assign cfg_rdata_o  = cfg_rdata_q;
  assign cfg_err_o    = cfg_err_q;
  assign locked_o     = locked_q;

endmodule

// File: tb/tb_soc_addr_map_unit.sv
// Directed bench for soc_addr_map_unit: lookup, config, stall, lock and reset scenarios.
// The stats scenario is compiled in when ADDR_MAP_STATS_EN is defined.
module tb_soc_addr_map_unit;
  localparam int NR = 10;
  localparam int AW = 64;
  localparam int IW = 4;

  function automatic logic [NR-1:0][AW-1:0] mk_base();
    logic [NR-1:0][AW-1:0] v;
    v = '0;
    v[0] = 64'h8000_0000;
    v[1] = 64'h1000_0000;
    v[2] = 64'hFFFF_FFFF_FFFF_F000;
    return v;
  endfunction
  function automatic logic [NR-1:0][AW-1:0] mk_len();
    logic [NR-1:0][AW-1:0] v;
    v = '0;
    v[0] = 64'h4000_0000;
    v[1] = 64'h100;
    v[2] = 64'h2000;
    return v;
  endfunction
  function automatic logic [NR-1:0][1:0] mk_attr();
    logic [NR-1:0][1:0] v;
    v = '0;
    v[0] = 2'b11;
    v[1] = 2'b01;
    v[2] = 2'b10;
    return v;
  endfunction

  localparam logic [NR-1:0][AW-1:0] RB = mk_base();
  localparam logic [NR-1:0][AW-1:0] RL = mk_len();
  localparam logic [NR-1:0][1:0]    RA = mk_attr();

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b1;
  logic [IW-1:0] rsp_idx_o;
  logic          rsp_hit_o, rsp_multi_o, rsp_exec_o, rsp_cached_o;
  logic          cfg_req_i = 1'b0;
  logic          cfg_we_i = 1'b0;
  logic [4:0]    cfg_idx_i = '0;
  logic [1:0]    cfg_field_i = '0;
  logic [AW-1:0] cfg_wdata_i = '0;
  logic [AW-1:0] cfg_rdata_o;
  logic          cfg_err_o;
  logic          lock_i = 1'b0;
  logic          locked_o;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  soc_addr_map_unit #(
    .NrRules(NR), .AddrWidth(AW), .IdxWidth(IW),
    .RstBase(RB), .RstLength(RL), .RstAttr(RA)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_idx_o(rsp_idx_o),
    .rsp_hit_o(rsp_hit_o), .rsp_multi_o(rsp_multi_o), .rsp_exec_o(rsp_exec_o),
    .rsp_cached_o(rsp_cached_o),
    .cfg_req_i(cfg_req_i), .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i),
    .cfg_field_i(cfg_field_i), .cfg_wdata_i(cfg_wdata_i), .cfg_rdata_o(cfg_rdata_o),
    .cfg_err_o(cfg_err_o), .lock_i(lock_i), .locked_o(locked_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one single-cycle config access; the registered result is visible on return.
  task automatic cfg_op(input logic we, input logic [4:0] idx, input logic [1:0] field,
                        input logic [AW-1:0] data);
    cfg_req_i = 1'b1; cfg_we_i = we; cfg_idx_i = idx; cfg_field_i = field; cfg_wdata_i = data;
    tick();
    cfg_req_i = 1'b0; cfg_we_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    #1;
    total++; if (rsp_valid_o !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid_o); end
    total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got %0b want 1", req_ready_o); end
    total++; if (locked_o !== 1'b0) begin bad++; $display("FAIL reset_locked: got %0b want 0", locked_o); end
    total++; if ({rsp_hit_o, rsp_multi_o, rsp_exec_o, rsp_cached_o, cfg_err_o} !== 5'b0) begin bad++; $display("FAIL reset_outputs: got %05b want 00000", {rsp_hit_o, rsp_multi_o, rsp_exec_o, rsp_cached_o, cfg_err_o}); end
    total++; if (cfg_rdata_o !== 64'h0) begin bad++; $display("FAIL reset_rdata: got %0h want 0", cfg_rdata_o); end
    $display("reset: rsp_valid=%0b req_ready=%0b locked=%0b", rsp_valid_o, req_ready_o, locked_o);
  endtask

  task automatic test_lookup();
    rsp_ready_i = 1'b1;
    req_valid_i = 1'b1; req_addr_i = 64'h8000_1000;
    tick();
    total++; if ({rsp_valid_o, rsp_hit_o, rsp_multi_o} !== 3'b110) begin bad++; $display("FAIL lookup_r0_flags: got v/h/m=%03b want 110", {rsp_valid_o, rsp_hit_o, rsp_multi_o}); end
    total++; if (rsp_idx_o !== 4'd0) begin bad++; $display("FAIL lookup_r0_idx: got %0d want 0", rsp_idx_o); end
    total++; if ({rsp_exec_o, rsp_cached_o} !== 2'b11) begin bad++; $display("FAIL lookup_r0_attr: got %02b want 11", {rsp_exec_o, rsp_cached_o}); end
    $display("lookup addr=80001000 idx=%0d hit=%0b", rsp_idx_o, rsp_hit_o);
    req_addr_i = 64'hC000_0000;
    tick();
    total++; if ({rsp_valid_o, rsp_hit_o, rsp_exec_o, rsp_cached_o} !== 4'b1000 || rsp_idx_o !== 4'd0) begin bad++; $display("FAIL lookup_end_excl: got v/h/e/c=%04b idx=%0d want 1000 idx=0", {rsp_valid_o, rsp_hit_o, rsp_exec_o, rsp_cached_o}, rsp_idx_o); end
    $display("lookup addr=c0000000 hit=%0b", rsp_hit_o);
    req_addr_i = 64'hBFFF_FFFF;
    tick();
    total++; if (rsp_hit_o !== 1'b1 || rsp_idx_o !== 4'd0) begin bad++; $display("FAIL lookup_last_byte: got hit=%0b idx=%0d want 1 0", rsp_hit_o, rsp_idx_o); end
    req_addr_i = 64'h7FFF_FFFF;
    tick();
    total++; if (rsp_hit_o !== 1'b0) begin bad++; $display("FAIL lookup_below_base: got hit=%0b want 0", rsp_hit_o); end
    req_addr_i = 64'h10;
    tick();
    total++; if (rsp_hit_o !== 1'b0) begin bad++; $display("FAIL lookup_no_wrap: got hit=%0b want 0", rsp_hit_o); end
    req_addr_i = 64'hFFFF_FFFF_FFFF_FFF0;
    tick();
    total++; if ({rsp_hit_o, rsp_exec_o, rsp_cached_o} !== 3'b101 || rsp_idx_o !== 4'd2) begin bad++; $display("FAIL lookup_top_rule: got h/e/c=%03b idx=%0d want 101 idx=2", {rsp_hit_o, rsp_exec_o, rsp_cached_o}, rsp_idx_o); end
    req_valid_i = 1'b0;
    tick();
    total++; if (rsp_valid_o !== 1'b0) begin bad++; $display("FAIL lookup_drain: got valid=%0b want 0", rsp_valid_o); end
  endtask

  task automatic test_cfg_write();
    cfg_op(1'b1, 5'd3, 2'd0, 64'h8000_0000);
    total++; if (cfg_err_o !== 1'b0) begin bad++; $display("FAIL cfg_wr_base_err: got %0b want 0", cfg_err_o); end
    // Length write and lookup in the same cycle: the lookup still sees the old (disabled) rule.
    cfg_req_i = 1'b1; cfg_we_i = 1'b1; cfg_idx_i = 5'd3; cfg_field_i = 2'd1; cfg_wdata_i = 64'h1000;
    req_valid_i = 1'b1; req_addr_i = 64'h8000_0800;
    tick();
    cfg_req_i = 1'b0; cfg_we_i = 1'b0;
    total++; if (rsp_multi_o !== 1'b0 || rsp_idx_o !== 4'd0 || rsp_hit_o !== 1'b1) begin bad++; $display("FAIL cfg_same_cycle: got multi=%0b idx=%0d hit=%0b want 0 0 1", rsp_multi_o, rsp_idx_o, rsp_hit_o); end
    tick();
    total++; if (rsp_multi_o !== 1'b1 || rsp_idx_o !== 4'd0) begin bad++; $display("FAIL cfg_next_cycle: got multi=%0b idx=%0d want 1 0", rsp_multi_o, rsp_idx_o); end
    $display("cfg write r3 then lookup 80000800 multi=%0b", rsp_multi_o);
    req_valid_i = 1'b0;
    cfg_op(1'b0, 5'd3, 2'd1, '0);
    total++; if (cfg_rdata_o !== 64'h1000 || cfg_err_o !== 1'b0) begin bad++; $display("FAIL cfg_rd_len: got %0h err=%0b want 1000 0", cfg_rdata_o, cfg_err_o); end
    cfg_op(1'b0, 5'd1, 2'd2, '0);
    total++; if (cfg_rdata_o !== 64'h1) begin bad++; $display("FAIL cfg_rd_attr: got %0h want 1", cfg_rdata_o); end
    cfg_op(1'b0, 5'd12, 2'd0, '0);
    total++; if (cfg_rdata_o !== 64'h0 || cfg_err_o !== 1'b1) begin bad++; $display("FAIL cfg_rd_range: got %0h err=%0b want 0 1", cfg_rdata_o, cfg_err_o); end
    tick();
    total++; if (cfg_err_o !== 1'b0) begin bad++; $display("FAIL cfg_err_pulse: got %0b want 0", cfg_err_o); end
    cfg_op(1'b1, 5'd3, 2'd3, 64'h55);
    total++; if (cfg_err_o !== 1'b1) begin bad++; $display("FAIL cfg_wr_stats: got err=%0b want 1", cfg_err_o); end
    cfg_op(1'b1, 5'd10, 2'd0, 64'h55);
    total++; if (cfg_err_o !== 1'b1) begin bad++; $display("FAIL cfg_wr_range: got err=%0b want 1", cfg_err_o); end
`ifndef ADDR_MAP_STATS_EN
    cfg_op(1'b0, 5'd0, 2'd3, '0);
    total++; if (cfg_rdata_o !== 64'h0 || cfg_err_o !== 1'b0) begin bad++; $display("FAIL cfg_rd_stats_off: got %0h err=%0b want 0 0", cfg_rdata_o, cfg_err_o); end
`endif
  endtask

  task automatic test_back_to_back();
    rsp_ready_i = 1'b1;
    req_valid_i = 1'b1; req_addr_i = 64'h8000_0010;
    tick();
    rsp_ready_i = 1'b0; req_addr_i = 64'h1000_0004;
    #1;
    total++; if (req_ready_o !== 1'b0) begin bad++; $display("FAIL stall_ready: got %0b want 0", req_ready_o); end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if ({rsp_valid_o, rsp_hit_o, rsp_multi_o} !== 3'b111 || rsp_idx_o !== 4'd0 || req_ready_o !== 1'b0) begin bad++; $display("FAIL stall_hold%0d: got v/h/m=%03b idx=%0d rdy=%0b want 111 0 0", k, {rsp_valid_o, rsp_hit_o, rsp_multi_o}, rsp_idx_o, req_ready_o); end
      $display("stall cycle %0d idx=%0d multi=%0b", k, rsp_idx_o, rsp_multi_o);
    end
    rsp_ready_i = 1'b1;
    #1;
    total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL release_ready: got %0b want 1", req_ready_o); end
    tick();
    total++; if (rsp_valid_o !== 1'b1 || rsp_idx_o !== 4'd1 || {rsp_exec_o, rsp_cached_o, rsp_multi_o} !== 3'b100) begin bad++; $display("FAIL b2b_r1: got idx=%0d e/c/m=%03b want 1 100", rsp_idx_o, {rsp_exec_o, rsp_cached_o, rsp_multi_o}); end
    req_addr_i = 64'h9000_0000;
    tick();
    total++; if (rsp_valid_o !== 1'b1 || rsp_idx_o !== 4'd0 || rsp_multi_o !== 1'b0 || rsp_hit_o !== 1'b1) begin bad++; $display("FAIL b2b_r0: got idx=%0d m=%0b h=%0b want 0 0 1", rsp_idx_o, rsp_multi_o, rsp_hit_o); end
    req_addr_i = 64'hFFFF_FFFF_FFFF_FFF0;
    tick();
    total++; if (rsp_valid_o !== 1'b1 || rsp_idx_o !== 4'd2) begin bad++; $display("FAIL b2b_r2: got v=%0b idx=%0d want 1 2", rsp_valid_o, rsp_idx_o); end
    req_valid_i = 1'b0;
    tick();
    total++; if (rsp_valid_o !== 1'b0) begin bad++; $display("FAIL b2b_drain: got valid=%0b want 0", rsp_valid_o); end
  endtask

  task automatic test_lock();
    lock_i = 1'b1;
    cfg_op(1'b1, 5'd4, 2'd0, 64'h1234);
    lock_i = 1'b0;
    total++; if (locked_o !== 1'b1 || cfg_err_o !== 1'b0) begin bad++; $display("FAIL lock_set: got locked=%0b err=%0b want 1 0", locked_o, cfg_err_o); end
    cfg_op(1'b1, 5'd1, 2'd0, 64'hDEAD);
    total++; if (cfg_err_o !== 1'b1) begin bad++; $display("FAIL lock_wr_err: got %0b want 1", cfg_err_o); end
    cfg_op(1'b0, 5'd1, 2'd0, '0);
    total++; if (cfg_rdata_o !== 64'h1000_0000 || cfg_err_o !== 1'b0) begin bad++; $display("FAIL lock_rd_old: got %0h err=%0b want 10000000 0", cfg_rdata_o, cfg_err_o); end
    cfg_op(1'b0, 5'd4, 2'd0, '0);
    total++; if (cfg_rdata_o !== 64'h1234) begin bad++; $display("FAIL lock_same_cycle_wr: got %0h want 1234", cfg_rdata_o); end
    $display("lock: locked=%0b r1 base=%0h", locked_o, 64'h1000_0000);
    // Reset while a result is stalled in the output register.
    rsp_ready_i = 1'b0; req_valid_i = 1'b1; req_addr_i = 64'h9000_0000;
    tick();
    total++; if (rsp_valid_o !== 1'b1) begin bad++; $display("FAIL inflight_valid: got %0b want 1", rsp_valid_o); end
    rst_i = 1'b1; req_valid_i = 1'b0;
    tick();
    rst_i = 1'b0;
    total++; if (rsp_valid_o !== 1'b0 || locked_o !== 1'b0 || req_ready_o !== 1'b1) begin bad++; $display("FAIL rst_clear: got v=%0b lock=%0b rdy=%0b want 0 0 1", rsp_valid_o, locked_o, req_ready_o); end
    rsp_ready_i = 1'b1;
    cfg_op(1'b0, 5'd3, 2'd1, '0);
    total++; if (cfg_rdata_o !== 64'h0) begin bad++; $display("FAIL rst_r3_len: got %0h want 0", cfg_rdata_o); end
    cfg_op(1'b0, 5'd4, 2'd0, '0);
    total++; if (cfg_rdata_o !== 64'h0) begin bad++; $display("FAIL rst_r4_base: got %0h want 0", cfg_rdata_o); end
    cfg_op(1'b0, 5'd1, 2'd0, '0);
    total++; if (cfg_rdata_o !== 64'h1000_0000) begin bad++; $display("FAIL rst_r1_base: got %0h want 10000000", cfg_rdata_o); end
    $display("reset after lock: locked=%0b", locked_o);
  endtask

`ifdef ADDR_MAP_STATS_EN
  task automatic test_stats();
    rsp_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      req_valid_i = 1'b1; req_addr_i = 64'h8000_0000 + 64'(k) * 64'h2000;
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      req_addr_i = 64'h0;
      tick();
    end
    req_valid_i = 1'b0;
    tick();
    cfg_op(1'b0, 5'd0, 2'd3, '0);
    total++; if (cfg_rdata_o !== 64'd5 || cfg_err_o !== 1'b0) begin bad++; $display("FAIL stats_hit_r0: got %0d err=%0b want 5 0", cfg_rdata_o, cfg_err_o); end
    cfg_op(1'b0, 5'd10, 2'd3, '0);
    total++; if (cfg_rdata_o !== 64'd2 || cfg_err_o !== 1'b0) begin bad++; $display("FAIL stats_miss: got %0d err=%0b want 2 0", cfg_rdata_o, cfg_err_o); end
    cfg_op(1'b0, 5'd1, 2'd3, '0);
    total++; if (cfg_rdata_o !== 64'd0) begin bad++; $display("FAIL stats_hit_r1: got %0d want 0", cfg_rdata_o); end
    $display("stats: r0 hits=5 misses=2 expected");
  endtask
`endif

  initial begin
    test_reset();
    test_lookup();
    test_cfg_write();
    test_back_to_back();
    test_lock();
`ifdef ADDR_MAP_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
